sbqm_queue_ctrl: RTL and testbench
==================================

SBQM_QUEUE_CTRL -- requirements
Module: sbqm_queue_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth per sensor input; legal range 2..4.
REQ-002 Parameter MAX_P, default 7: queue capacity in persons; legal range 1..7.
REQ-003 clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 rst_n, input, 1: asynchronous, active-low reset.
REQ-005 back_sensor, input, 1: asynchronous photocell at the queue entry; a rising edge means one person entered.
REQ-006 front_sensor, input, 1: asynchronous photocell at the queue head; a rising edge means one person left to a teller.
REQ-007 tcount, input, 2: number of open tellers (0..3); quasi-static.
REQ-008 pcount, output, 3: registered count of persons in the queue.
REQ-009 wtime, output, 5: registered estimated wait time in minutes.
REQ-010 full, output, 1: registered; high when pcount == MAX_P.
REQ-011 empty, output, 1: registered; high when pcount == 0.
REQ-012 ovf_err, output, 1: registered one-cycle pulse; an entry was rejected because the queue was full.
REQ-013 unf_err, output, 1: registered one-cycle pulse; an exit was rejected because the queue was empty.

Function
REQ-014 Each sensor shall pass through a SYNC_STAGES-flop synchronizer followed by one history flop; an event shall be synchronized-high AND history-low, giving one event per rising edge regardless of pulse width.
REQ-015 Latency: if a sensor is first sampled high at edge E0, pcount, full, empty and the error pulses shall update at edge E0+SYNC_STAGES.
REQ-016 The FSM shall have three states: EMPTY (pcount=0), PARTIAL (0<pcount<MAX_P) and FULL (pcount=MAX_P); full and empty shall be decoded from the state.
REQ-017 Entry only: in EMPTY or PARTIAL, pcount shall increment by 1; in FULL, pcount shall hold and ovf_err shall pulse.
REQ-018 Exit only: in PARTIAL or FULL, pcount shall decrement by 1; in EMPTY, pcount shall hold and unf_err shall pulse.
REQ-019 Simultaneous entry and exit in the same cycle: in PARTIAL, pcount shall hold with no error pulse.
REQ-020 Simultaneous entry and exit in EMPTY: the entry is counted and the exit is rejected, so pcount becomes 1 and unf_err pulses.
REQ-021 Simultaneous entry and exit in FULL: the exit is counted and the entry is rejected, so pcount becomes MAX_P-1 and ovf_err pulses.
REQ-022 FSM transitions: EMPTY->PARTIAL on a counted entry; PARTIAL->FULL when the count reaches MAX_P; PARTIAL->EMPTY when the count reaches 0; FULL->PARTIAL on a counted exit; all other cases hold.
REQ-023 If MAX_P == 1, the FSM shall go EMPTY<->FULL directly and never enter PARTIAL.
REQ-024 pcount shall never wrap; it shall stay within 0..MAX_P in all cases.
REQ-025 tcount shall be registered every cycle into t_reg.
REQ-026 wtime shall be registered one edge after pcount/t_reg change: wtime = floor(3*(pcount + t_reg - 1) / t_reg).
REQ-027 wtime shall be 0 when pcount == 0 or t_reg == 0.
REQ-028 The divider shall be implemented as a constant lookup, not an iterative divider; the result shall fit in 5 bits (maximum 21).
REQ-029 Table of wtime for p=1..7: t=1 gives 3,6,9,12,15,18,21; t=2 gives 3,4,6,7,9,10,12; t=3 gives 3,4,5,6,7,8,9.
REQ-030 A change of tcount shall be visible on wtime at the second rising edge after the change is sampled, with no effect on pcount.

Reset
REQ-031 While rst_n is low: state=EMPTY, pcount=0, wtime=0, full=0, empty=1, ovf_err=0, unf_err=0, and all synchronizer, history and t_reg flops = 0.
REQ-032 Reset assertion mid-operation shall clear all state immediately, without waiting for a clock edge.
REQ-033 After reset release, a sensor already held high shall register as one event once synchronized, because history=0.

Verification
REQ-034 Reset then tcount=1, then 3 back_sensor pulses -> pcount=3, wtime=9 one edge later, empty=0, full=0.
REQ-035 tcount=2, then 8 back_sensor pulses -> pcount=7, full=1, wtime=12; the 8th pulse gives ovf_err for exactly one cycle with pcount held at 7.
REQ-036 With pcount=0, one front_sensor pulse -> unf_err pulses once; pcount=0, empty=1, wtime=0.
REQ-037 With pcount=4, both sensors rising in the same cycle -> pcount=4 with no error pulse; the same stimulus at pcount=7 -> pcount=6 and ovf_err pulses once.
REQ-038 One back_sensor held high for 20 cycles -> exactly one increment, first visible at E0+SYNC_STAGES.
REQ-039 With pcount=5 and tcount changed 3->0->1 -> wtime goes 7->0->15, each change two edges after tcount changes; then rst_n pulsed low mid-cycle -> all outputs reach reset values asynchronously.

Source files
------------

// File: rtl/sbqm_queue_ctrl.sv
// Bank queue controller: counts people passing two photocells and estimates
// the wait time from the queue length and the number of open tellers.
module sbqm_queue_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_P       = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       back_sensor,
    input  logic       front_sensor,
    input  logic [1:0] tcount,
    output logic [2:0] pcount,
    output logic [4:0] wtime,
    output logic       full,
    output logic       empty,
    output logic       ovf_err,
    output logic       unf_err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    localparam logic [2:0] MAX_CNT = 3'(MAX_P);

    state_t                 r_state;
    logic [2:0]             r_pcount;
    logic [4:0]             r_wtime;
    logic [1:0]             r_treg;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_ovf;
    logic                   r_unf;
    logic [SYNC_STAGES-1:0] r_back_sync;
    logic [SYNC_STAGES-1:0] r_front_sync;
    logic                   r_back_hist;
    logic                   r_front_hist;
    logic                   w_entry;
    logic                   w_exit;

    // One event per rising edge: synchronized level high while history still low.
    assign w_entry = r_back_sync[SYNC_STAGES-1] & ~r_back_hist;
    assign w_exit  = r_front_sync[SYNC_STAGES-1] & ~r_front_hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_back_sync  <= '0;
            r_front_sync <= '0;
            r_back_hist  <= 1'b0;
            r_front_hist <= 1'b0;
            r_treg       <= 2'd0;
        end else begin
            r_back_sync  <= {r_back_sync[SYNC_STAGES-2:0], back_sensor};
            r_front_sync <= {r_front_sync[SYNC_STAGES-2:0], front_sensor};
            r_back_hist  <= r_back_sync[SYNC_STAGES-1];
            r_front_hist <= r_front_sync[SYNC_STAGES-1];
            r_treg       <= tcount;
        end
    end

    // Simultaneous events at the boundaries: the legal one is counted, the other flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_EMPTY;
            r_pcount <= 3'd0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            case (r_state)
                ST_EMPTY: begin
                    if (w_exit) r_unf <= 1'b1;
                    if (w_entry) begin
                        r_pcount <= 3'd1;
                        r_empty  <= 1'b0;
                        if (MAX_P == 1) begin
                            r_state <= ST_FULL;
                            r_full  <= 1'b1;
                        end else begin
                            r_state <= ST_PARTIAL;
                        end
                    end
                end
                ST_PARTIAL: begin
                    if (w_entry && !w_exit) begin
                        r_pcount <= r_pcount + 3'd1;
                        if (r_pcount + 3'd1 == MAX_CNT) begin
                            r_state <= ST_FULL;
                            r_full  <= 1'b1;
                        end
                    end else if (w_exit && !w_entry) begin
                        r_pcount <= r_pcount - 3'd1;
                        if (r_pcount == 3'd1) begin
                            r_state <= ST_EMPTY;
                            r_empty <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (w_entry) r_ovf <= 1'b1;
                    if (w_exit) begin
                        r_pcount <= MAX_CNT - 3'd1;
                        r_full   <= 1'b0;
                        if (MAX_P == 1) begin
                            r_state <= ST_EMPTY;
                            r_empty <= 1'b1;
                        end else begin
                            r_state <= ST_PARTIAL;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_EMPTY;
                    r_pcount <= 3'd0;
                    r_full   <= 1'b0;
                    r_empty  <= 1'b1;
                end
            endcase
        end
    end

    // floor(3*(p+t-1)/t) tabulated for every legal p and t; zero when p or t is zero.
    function automatic logic [4:0] wait_lut(input logic [2:0] p, input logic [1:0] t);
        logic [4:0] v;
        v = 5'd0;
        case (t)
            2'd1: case (p)
                3'd1: v = 5'd3;  3'd2: v = 5'd6;  3'd3: v = 5'd9;  3'd4: v = 5'd12;
                3'd5: v = 5'd15; 3'd6: v = 5'd18; 3'd7: v = 5'd21; default: v = 5'd0;
            endcase
            2'd2: case (p)
                3'd1: v = 5'd3;  3'd2: v = 5'd4;  3'd3: v = 5'd6;  3'd4: v = 5'd7;
                3'd5: v = 5'd9;  3'd6: v = 5'd10; 3'd7: v = 5'd12; default: v = 5'd0;
            endcase
            2'd3: case (p)
                3'd1: v = 5'd3;  3'd2: v = 5'd4;  3'd3: v = 5'd5;  3'd4: v = 5'd6;
                3'd5: v = 5'd7;  3'd6: v = 5'd8;  3'd7: v = 5'd9;  default: v = 5'd0;
            endcase
            default: v = 5'd0;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wtime <= 5'd0;
        else        r_wtime <= wait_lut(r_pcount, r_treg);
    end

    assign pcount    = r_pcount;
    assign wtime     = r_wtime;
    assign full      = r_full;
    assign empty     = r_empty;
    assign ovf_err   = r_ovf;
    assign unf_err   = r_unf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_sbqm_queue_ctrl.sv
// Bench for sbqm_queue_ctrl: directed scenarios plus randomized sensor traffic
// checked against an arithmetic model of the queue.
module tb_sbqm_queue_ctrl;

    localparam int SS   = 2;
    localparam int MAXP = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       back_sensor = 1'b0;
    logic       front_sensor = 1'b0;
    logic [1:0] tcount = 2'd0;
    logic [2:0] pcount;
    logic [4:0] wtime;
    logic       full, empty, ovf_err, unf_err;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int m_p      = 0;
    int ovf_seen = 0;
    int unf_seen = 0;
    int exp_ovf  = 0;
    int exp_unf  = 0;

    sbqm_queue_ctrl #(.SYNC_STAGES(SS), .MAX_P(MAXP)) dut (
        .clk(clk), .rst_n(rst_n), .back_sensor(back_sensor), .front_sensor(front_sensor),
        .tcount(tcount), .pcount(pcount), .wtime(wtime), .full(full), .empty(empty),
        .ovf_err(ovf_err), .unf_err(unf_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic int model_wtime(input int p, input int t);
        if (p == 0 || t == 0) return 0;
        return (3 * (p + t - 1)) / t;
    endfunction

    // Queue rules: people cannot leave an empty queue nor join a full one.
    function automatic void model_event(input bit b, input bit f);
        exp_ovf = 0;
        exp_unf = 0;
        if (b && f) begin
            if (m_p == 0) begin m_p = 1; exp_unf = 1; end
            else if (m_p == MAXP) begin m_p = MAXP - 1; exp_ovf = 1; end
        end else if (b) begin
            if (m_p == MAXP) exp_ovf = 1; else m_p = m_p + 1;
        end else if (f) begin
            if (m_p == 0) exp_unf = 1; else m_p = m_p - 1;
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_p = 0;
        repeat (2) @(negedge clk);
    endtask

    // Raise the chosen sensors for hold cycles, release, and count error pulses until settled.
    task automatic send(input bit b, input bit f, input int hold);
        @(negedge clk);
        back_sensor  = b;
        front_sensor = f;
        ovf_seen = 0;
        unf_seen = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (ovf_err) ovf_seen++;
            if (unf_err) unf_seen++;
        end
        back_sensor  = 1'b0;
        front_sensor = 1'b0;
        for (int i = 0; i < SS + 4; i++) begin
            @(negedge clk);
            if (ovf_err) ovf_seen++;
            if (unf_err) unf_seen++;
        end
        model_event(b, f);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        back_sensor = 1'b1;
        #1;
        n_checks++; if (pcount !== 3'd0) $display("FAIL reset_pcount: got %0d want 0", pcount); else n_pass++;
        n_checks++; if (wtime !== 5'd0) $display("FAIL reset_wtime: got %0d want 0", wtime); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (ovf_err !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf_err); else n_pass++;
        n_checks++; if (unf_err !== 1'b0) $display("FAIL reset_unf: got %b want 0", unf_err); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (pcount !== 3'd0) $display("FAIL reset_hold_pcount: got %0d want 0", pcount); else n_pass++;
        rst_n = 1'b1;
        m_p = 0;
        repeat (SS + 3) @(negedge clk);
        n_checks++; if (pcount !== 3'd1) $display("FAIL reset_held_sensor: got %0d want 1", pcount); else n_pass++;
        back_sensor = 1'b0;
        repeat (SS + 3) @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        tcount = 2'd1;
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 1);
        n_checks++; if (pcount !== 3'(m_p)) $display("FAIL basic_pcount: got %0d want %0d", pcount, m_p); else n_pass++;
        n_checks++; if (32'(wtime) !== model_wtime(m_p, 1)) $display("FAIL basic_wtime: got %0d want %0d", wtime, model_wtime(m_p, 1)); else n_pass++;
        n_checks++; if (empty !== 1'b0 || full !== 1'b0) $display("FAIL basic_flags: got full=%b empty=%b want 0/0", full, empty); else n_pass++;
    endtask

    task automatic test_fill();
        do_reset();
        tcount = 2'd2;
        for (int i = 0; i < 8; i++) send(1'b1, 1'b0, 1);
        n_checks++; if (pcount !== 3'(m_p)) $display("FAIL fill_pcount: got %0d want %0d", pcount, m_p); else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full); else n_pass++;
        n_checks++; if (32'(wtime) !== model_wtime(m_p, 2)) $display("FAIL fill_wtime: got %0d want %0d", wtime, model_wtime(m_p, 2)); else n_pass++;
        n_checks++; if (ovf_seen !== exp_ovf) $display("FAIL fill_ovf_cycles: got %0d want %0d", ovf_seen, exp_ovf); else n_pass++;
    endtask

    task automatic test_underflow();
        do_reset();
        send(1'b0, 1'b1, 2);
        n_checks++; if (unf_seen !== exp_unf) $display("FAIL unf_pulses: got %0d want %0d", unf_seen, exp_unf); else n_pass++;
        n_checks++; if (pcount !== 3'(m_p)) $display("FAIL unf_pcount: got %0d want %0d", pcount, m_p); else n_pass++;
        n_checks++; if (empty !== 1'b1 || wtime !== 5'd0) $display("FAIL unf_empty_wtime: got empty=%b wtime=%0d want 1/0", empty, wtime); else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        tcount = 2'd1;
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 1);
        send(1'b1, 1'b1, 1);
        n_checks++; if (pcount !== 3'(m_p)) $display("FAIL simul_mid_pcount: got %0d want %0d", pcount, m_p); else n_pass++;
        n_checks++; if (ovf_seen != 0 || unf_seen != 0) $display("FAIL simul_mid_err: got ovf=%0d unf=%0d want 0/0", ovf_seen, unf_seen); else n_pass++;
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0, 1);
        send(1'b1, 1'b1, 1);
        n_checks++; if (pcount !== 3'(m_p)) $display("FAIL simul_full_pcount: got %0d want %0d", pcount, m_p); else n_pass++;
        n_checks++; if (ovf_seen !== exp_ovf) $display("FAIL simul_full_ovf: got %0d want %0d", ovf_seen, exp_ovf); else n_pass++;
        do_reset();
        send(1'b1, 1'b1, 1);
        n_checks++; if (pcount !== 3'(m_p) || unf_seen !== exp_unf) $display("FAIL simul_empty: got p=%0d unf=%0d want %0d/%0d", pcount, unf_seen, m_p, exp_unf); else n_pass++;
    endtask

    task automatic test_hold();
        do_reset();
        @(negedge clk);
        back_sensor = 1'b1;
        repeat (SS) @(negedge clk);
        n_checks++; if (pcount !== 3'd0) $display("FAIL hold_early: got %0d want 0", pcount); else n_pass++;
        @(negedge clk);
        n_checks++; if (pcount !== 3'd1) $display("FAIL hold_latency: got %0d want 1", pcount); else n_pass++;
        repeat (20 - SS - 1) @(negedge clk);
        back_sensor = 1'b0;
        repeat (SS + 3) @(negedge clk);
        m_p = 1;
        n_checks++; if (pcount !== 3'd1) $display("FAIL hold_single: got %0d want 1", pcount); else n_pass++;
    endtask

    task automatic step_tcount(input logic [1:0] t_new, input int old_w, input string nm);
        @(negedge clk);
        tcount = t_new;
        @(negedge clk);
        n_checks++; if (32'(wtime) !== old_w) $display("FAIL %s_early: got %0d want %0d", nm, wtime, old_w); else n_pass++;
        @(negedge clk);
        n_checks++; if (32'(wtime) !== model_wtime(m_p, int'(t_new))) $display("FAIL %s_late: got %0d want %0d", nm, wtime, model_wtime(m_p, int'(t_new))); else n_pass++;
    endtask

    task automatic test_tcount();
        do_reset();
        tcount = 2'd3;
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1);
        n_checks++; if (32'(wtime) !== model_wtime(m_p, 3)) $display("FAIL tcount_start: got %0d want %0d", wtime, model_wtime(m_p, 3)); else n_pass++;
        step_tcount(2'd0, model_wtime(m_p, 3), "tcount_to0");
        step_tcount(2'd1, 0, "tcount_to1");
        n_checks++; if (pcount !== 3'(m_p)) $display("FAIL tcount_pcount: got %0d want %0d", pcount, m_p); else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pcount !== 3'd0 || wtime !== 5'd0) $display("FAIL async_rst_counts: got p=%0d w=%0d want 0/0", pcount, wtime); else n_pass++;
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL async_rst_flags: got full=%b empty=%b want 0/1", full, empty); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        m_p = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        bit b, f;
        int sel;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 4) == 0) tcount = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 5);
            b = (sel <= 2) || (sel == 5);
            f = (sel == 3) || (sel == 4) || (sel == 5);
            send(b, f, $urandom_range(1, 5));
            n_checks++; if (pcount !== 3'(m_p)) $display("FAIL rand_pcount it=%0d: got %0d want %0d", it, pcount, m_p); else n_pass++;
            n_checks++; if (32'(wtime) !== model_wtime(m_p, int'(tcount))) $display("FAIL rand_wtime it=%0d: got %0d want %0d", it, wtime, model_wtime(m_p, int'(tcount))); else n_pass++;
            n_checks++; if (full !== (m_p == MAXP) || empty !== (m_p == 0)) $display("FAIL rand_flags it=%0d: got full=%b empty=%b p=%0d", it, full, empty, m_p); else n_pass++;
            n_checks++; if (ovf_seen !== exp_ovf || unf_seen !== exp_unf) $display("FAIL rand_err it=%0d: got ovf=%0d unf=%0d want %0d/%0d", it, ovf_seen, unf_seen, exp_ovf, exp_unf); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_underflow();
        test_simultaneous();
        test_hold();
        test_tcount();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
